// File: rtl/axi_fifo_pkt.sv
// axi_fifo_pkt: single-clock AXI-Stream FIFO with optional store-and-forward packet mode and 2-stage output prefetch
module axi_fifo_pkt #(
  parameter int DATA_WIDTH          = 32,
  parameter int ADDR_WIDTH          = 8,
  parameter int ALMOST_FULL_THRESH  = 16,
  parameter int ALMOST_EMPTY_THRESH = 4,
  parameter int PACKET_MODE         = 0
) (
  input  logic                  clk,
  input  logic                  async_reset_n,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH+1:0] data_count,
  output logic [ADDR_WIDTH:0]   pkt_count
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int PW = ADDR_WIDTH + 1;
  localparam int CW = ADDR_WIDTH + 2;
  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [DATA_WIDTH:0] d0, d1, rd_word;
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic [1:0] occ, occ_n;
  logic [CW-1:0] dc_n;
  logic full, empty, wr_en, rd_en, ld1, rd_enable, cut_thru, inc, dec;
  assign full = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) && (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign empty = wr_ptr == rd_ptr;
  assign wr_en = s_axis_tvalid && !full;
  assign rd_enable = (PACKET_MODE == 0) || (pkt_count != '0) || cut_thru;
  assign rd_en = (occ != 2'b11 || m_axis_tready) && !empty && rd_enable;
  assign ld1 = m_axis_tready || !occ[1];
  assign rd_word = mem[rd_ptr[ADDR_WIDTH-1:0]];
  assign inc = wr_en && s_axis_tlast;
  assign dec = rd_en && rd_word[DATA_WIDTH];
  assign wr_ptr_n = wr_ptr + PW'(wr_en);
  assign rd_ptr_n = rd_ptr + PW'(rd_en);
  // d0 fills on a RAM read, otherwise empties when it shifts into d1
  assign occ_n = {ld1 ? occ[0] : occ[1], rd_en || (occ[0] && !ld1)};
  assign dc_n = CW'(wr_ptr_n - rd_ptr_n) + CW'(occ_n[0]) + CW'(occ_n[1]);
  assign s_axis_tready = !full;
  assign m_axis_tvalid = occ[1];
  assign m_axis_tdata = d1[DATA_WIDTH-1:0];
  assign m_axis_tlast = d1[DATA_WIDTH];
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
  always_ff @(posedge clk or negedge async_reset_n)
    if (!async_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ <= '0;
      d0 <= '0;
      d1 <= '0;
      pkt_count <= '0;
      cut_thru <= 1'b0;
      data_count <= '0;
      almost_full <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      occ <= occ_n;
      if (rd_en) d0 <= rd_word;
      if (ld1) d1 <= d0;
      pkt_count <= pkt_count + PW'(inc) - PW'(dec);
      // a full RAM with no complete packet can only drain cut-through until its tlast leaves
      cut_thru <= (PACKET_MODE != 0) && (dec ? 1'b0 : (cut_thru || (full && pkt_count == '0)));
      data_count <= dc_n;
      almost_full <= data_count >= CW'(ALMOST_FULL_THRESH);
      almost_empty <= data_count <= CW'(ALMOST_EMPTY_THRESH);
    end
endmodule
